// File: rtl/x_ramb_sp_gen_pkg.sv
// Shared types and helpers for the parametrised single-port block-RAM model:
// write-mode encodings, lane count and byte-lane merge.
package x_ramb_pkg;

  typedef enum logic [1:0] {
    WR_FIRST = 2'b00,
    RD_FIRST = 2'b01,
    NO_CHG   = 2'b10
  } wr_mode_e;

  // Widest word the lane helpers handle; callers size-cast in and out.
  localparam int unsigned MAX_DW = 256;

  function automatic int unsigned nbyte(input int unsigned dw, input int unsigned bw);
    return (bw == 0) ? 0 : dw / bw;
  endfunction

  // Expand per-lane write enables into a per-bit mask covering dw bits.
  function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_DW-1:0] we,
                                                  input int unsigned dw,
                                                  input int unsigned bw);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (i < dw) m[i] = we[i / bw];
    end
    return m;
  endfunction

  function automatic logic [MAX_DW-1:0] merge_lanes(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_DW-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/x_ramb_sp_gen_if.sv
// Port bundle of x_ramb_sp_gen: control, address and data to the RAM, read data back.
interface x_ramb_sp_gen_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NBYTE      = 1
);
  logic                  EN;
  logic                  SSR;
  logic [NBYTE-1:0]      WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DI;
  logic                  REGCE;
  logic [DATA_WIDTH-1:0] DO;
  logic                  DOV;

  modport master (output EN, SSR, WE, ADDR, DI, REGCE, input DO, DOV);
  modport slave  (input EN, SSR, WE, ADDR, DI, REGCE, output DO, DOV);
endinterface

// File: rtl/x_ramb_sp_gen_out_reg.sv
// Optional second output stage: data + valid register with clock enable,
// synchronous set/reset to SRVAL and asynchronous active-low reset.
module x_ramb_out_reg #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  SRVAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  ssr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  d_v,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_v
);

  logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
  logic                  ov_q, ov_d;

  always_comb begin
    oreg_d = oreg_q;
    ov_d   = ov_q;
    if (ce) begin
      if (ssr) begin
        oreg_d = SRVAL;
        ov_d   = 1'b0;
      end else begin
        oreg_d = d;
        ov_d   = d_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_q <= SRVAL;
      ov_q   <= 1'b0;
    end else begin
      oreg_q <= oreg_d;
      ov_q   <= ov_d;
    end
  end

  assign q   = oreg_q;
  assign q_v = ov_q;

endmodule

// File: rtl/x_ramb_sp_gen.sv
// Parametrised single-port block RAM with byte-lane writes, selectable
// write/read collision mode, optional output register and read-valid flag.
module x_ramb_sp_gen
  import x_ramb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 11,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter string                 WRITE_MODE = "WRITE_FIRST",
  parameter int unsigned           DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input logic           CLK,
  input logic           RST_N,
  x_ramb_sp_gen_if.slave bus
);

  localparam int unsigned NBYTE = nbyte(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam wr_mode_e    MODE  = (WRITE_MODE == "READ_FIRST") ? RD_FIRST :
                                  (WRITE_MODE == "NO_CHANGE")  ? NO_CHG   : WR_FIRST;

  if (WRITE_MODE != "WRITE_FIRST" && WRITE_MODE != "READ_FIRST" &&
      WRITE_MODE != "NO_CHANGE") begin : g_bad_mode
    $fatal(1, "x_ramb_sp_gen: illegal WRITE_MODE %s", WRITE_MODE);
  end
  if (BYTE_WIDTH == 0 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "x_ramb_sp_gen: DATA_WIDTH %0d not a multiple of BYTE_WIDTH %0d",
           DATA_WIDTH, BYTE_WIDTH);
  end
  if (DATA_WIDTH > MAX_DW) begin : g_too_wide
    $fatal(1, "x_ramb_sp_gen: DATA_WIDTH %0d exceeds %0d", DATA_WIDTH, MAX_DW);
  end

  // Contents come up as INIT_WORD and are never touched by RST_N.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  any_we;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] lat_q, lat_d;
  logic                  lat_v_q, lat_v_d;

  logic [DATA_WIDTH-1:0] do_w;
  logic                  dov_w;

  always_comb begin
    rd_word     = mem_q[bus.ADDR];
    any_we      = |bus.WE;
    wr_en       = bus.EN && any_we;
    merged_word = DATA_WIDTH'(merge_lanes(MAX_DW'(rd_word), MAX_DW'(bus.DI),
                                          lane_mask(MAX_DW'(bus.WE), DATA_WIDTH, BYTE_WIDTH)));
  end

  // SSR only affects the output path; the write still lands.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[bus.ADDR] <= merged_word;
  end

  always_comb begin
    lat_d   = lat_q;
    lat_v_d = lat_v_q;
    if (bus.EN) begin
      if (bus.SSR) begin
        lat_d   = SRVAL;
        lat_v_d = 1'b0;
      end else if (!any_we) begin
        lat_d   = rd_word;
        lat_v_d = 1'b1;
      end else begin
        unique case (MODE)
          WR_FIRST: begin
            lat_d   = merged_word;
            lat_v_d = 1'b1;
          end
          RD_FIRST: begin
            lat_d   = rd_word;
            lat_v_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_q   <= SRVAL;
      lat_v_q <= 1'b0;
    end else begin
      lat_q   <= lat_d;
      lat_v_q <= lat_v_d;
    end
  end

  if (DO_REG != 0) begin : g_oreg
    x_ramb_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRVAL      (SRVAL)
    ) u_out_reg (
      .clk   (CLK),
      .rst_n (RST_N),
      .ce    (bus.REGCE),
      .ssr   (bus.SSR),
      .d     (lat_q),
      .d_v   (lat_v_q),
      .q     (do_w),
      .q_v   (dov_w)
    );
  end else begin : g_no_oreg
    logic unused_regce;
    assign unused_regce = bus.REGCE;
    assign do_w         = lat_q;
    assign dov_w        = lat_v_q;
  end

  assign bus.DO  = do_w;
  assign bus.DOV = dov_w;

endmodule

// File: tb/tb_x_ramb_sp_gen.sv
// Directed bench: four RAM variants (WRITE_FIRST, READ_FIRST, NO_CHANGE,
// WRITE_FIRST with output register) driven with identical stimulus.
module tb_x_ramb_sp_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NB = 2;
  localparam logic [DW-1:0] SR = 16'h00FF;
  localparam logic [DW-1:0] IW = 16'hBEEF;

  logic          clk;
  logic          rst_n;
  logic          en, ssr, regce;
  logic [NB-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;

  int n_checks = 0;
  int n_errors = 0;

  x_ramb_sp_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTE(NB)) if_wf ();
  x_ramb_sp_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTE(NB)) if_rf ();
  x_ramb_sp_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTE(NB)) if_nc ();
  x_ramb_sp_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTE(NB)) if_rg ();

  assign if_wf.EN = en;  assign if_wf.SSR = ssr;  assign if_wf.WE = we;
  assign if_wf.ADDR = addr;  assign if_wf.DI = di;  assign if_wf.REGCE = regce;
  assign if_rf.EN = en;  assign if_rf.SSR = ssr;  assign if_rf.WE = we;
  assign if_rf.ADDR = addr;  assign if_rf.DI = di;  assign if_rf.REGCE = regce;
  assign if_nc.EN = en;  assign if_nc.SSR = ssr;  assign if_nc.WE = we;
  assign if_nc.ADDR = addr;  assign if_nc.DI = di;  assign if_nc.REGCE = regce;
  assign if_rg.EN = en;  assign if_rg.SSR = ssr;  assign if_rg.WE = we;
  assign if_rg.ADDR = addr;  assign if_rg.DI = di;  assign if_rg.REGCE = regce;

  x_ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                  .WRITE_MODE("WRITE_FIRST"), .DO_REG(0),
                  .INIT_WORD(IW), .SRVAL(SR))
    u_wf (.CLK(clk), .RST_N(rst_n), .bus(if_wf));
  x_ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                  .WRITE_MODE("READ_FIRST"), .DO_REG(0),
                  .INIT_WORD(IW), .SRVAL(SR))
    u_rf (.CLK(clk), .RST_N(rst_n), .bus(if_rf));
  x_ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                  .WRITE_MODE("NO_CHANGE"), .DO_REG(0),
                  .INIT_WORD(IW), .SRVAL(SR))
    u_nc (.CLK(clk), .RST_N(rst_n), .bus(if_nc));
  x_ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                  .WRITE_MODE("WRITE_FIRST"), .DO_REG(1),
                  .INIT_WORD(IW), .SRVAL(SR))
    u_rg (.CLK(clk), .RST_N(rst_n), .bus(if_rg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got dov/do=%h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect4(input string tag,
                         input logic [DW-1:0] d_wf, input logic v_wf,
                         input logic [DW-1:0] d_rf, input logic v_rf,
                         input logic [DW-1:0] d_nc, input logic v_nc,
                         input logic [DW-1:0] d_rg, input logic v_rg);
    check({tag, "/wf"}, {if_wf.DOV, if_wf.DO}, {v_wf, d_wf});
    check({tag, "/rf"}, {if_rf.DOV, if_rf.DO}, {v_rf, d_rf});
    check({tag, "/nc"}, {if_nc.DOV, if_nc.DO}, {v_nc, d_nc});
    check({tag, "/rg"}, {if_rg.DOV, if_rg.DO}, {v_rg, d_rg});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ssr = 1'b0; regce = 1'b0;
    we = '0; addr = '0; di = '0;
    repeat (2) @(posedge clk);
    #1;
    expect4("reset", SR,0, SR,0, SR,0, SR,0);

    // untouched memory reads back the init word at both ends of the range
    rst_n = 1'b1; en = 1'b1; regce = 1'b1; addr = 4'd0;
    step(); expect4("init_a0",   IW,1, IW,1, IW,1, SR,0);
    addr = 4'd15;
    step(); expect4("init_amax", IW,1, IW,1, IW,1, IW,1);

    we = 2'b11; addr = 4'd5; di = 16'hA55A;
    step(); expect4("wr_full", 16'hA55A,1, IW,1, IW,1, IW,1);
    we = 2'b00;
    step(); expect4("rd_full", 16'hA55A,1, 16'hA55A,1, 16'hA55A,1, 16'hA55A,1);
    addr = 4'd15;
    step(); expect4("rd_other", IW,1, IW,1, IW,1, 16'hA55A,1);

    we = 2'b01; addr = 4'd5; di = 16'h1234;
    step(); expect4("wr_byte", 16'hA534,1, 16'hA55A,1, IW,1, IW,1);
    we = 2'b00;
    step(); expect4("rd_byte", 16'hA534,1, 16'hA534,1, 16'hA534,1, 16'hA534,1);

    // SSR resets outputs while the full-word write still reaches memory
    ssr = 1'b1; we = 2'b11; addr = 4'd3; di = 16'h0F0F;
    step(); expect4("ssr_wr", SR,0, SR,0, SR,0, SR,0);
    ssr = 1'b0; we = 2'b00;
    step(); expect4("rd_after_ssr", 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1, SR,0);
    step(); expect4("rd_after_ssr2", 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1);

    en = 1'b0; ssr = 1'b1; regce = 1'b0;
    step(); expect4("ssr_en0", 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1);

    // output register frozen for three reads, then releases the latest one
    en = 1'b1; ssr = 1'b0; addr = 4'd5;
    step(); expect4("frz1", 16'hA534,1, 16'hA534,1, 16'hA534,1, 16'h0F0F,1);
    addr = 4'd3;
    step(); expect4("frz2", 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1, 16'h0F0F,1);
    addr = 4'd0;
    step(); expect4("frz3", IW,1, IW,1, IW,1, 16'h0F0F,1);
    en = 1'b0; regce = 1'b1;
    step(); expect4("unfrz", IW,1, IW,1, IW,1, IW,1);

    en = 1'b1; addr = 4'd5;
    step(); expect4("pre_rst", 16'hA534,1, 16'hA534,1, 16'hA534,1, IW,1);
    #3;
    rst_n = 1'b0;
    #1;
    expect4("rst_async", SR,0, SR,0, SR,0, SR,0);
    we = 2'b11; addr = 4'd7; di = 16'h7777;
    step(); expect4("rst_held", SR,0, SR,0, SR,0, SR,0);

    rst_n = 1'b1; we = 2'b00;
    step(); expect4("rd_wr_in_rst", 16'h7777,1, 16'h7777,1, 16'h7777,1, SR,0);
    addr = 4'd5;
    step(); expect4("rd_after_rst", 16'hA534,1, 16'hA534,1, 16'hA534,1, 16'h7777,1);

    en = 1'b0; ssr = 1'b1; regce = 1'b1;
    step(); expect4("ssr_regce", 16'hA534,1, 16'hA534,1, 16'hA534,1, SR,0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
